piso_shift_tx: RTL and testbench



---
 rtl/piso_pkg.sv | 23 ++
 rtl/bit_period_counter.sv | 35 +++
 rtl/piso_shift_tx.sv | 136 +++++++++++++
 tb/tb_piso_shift_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter.
// Holds the state encoding, the serial idle level and the counter-width helper.
// No logic lives here, so it has no latency and no backpressure of its own.
package piso_pkg;

  // Shift FSM states: waiting for a word, or shifting one out.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Level driven on the serial line whenever no frame is active.
  localparam logic IDLE_LEVEL = 1'b1;

  // Bits needed to hold n distinct counter values (0..n-1), never less than 1.
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/bit_period_counter.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle.
// Latency: tc is combinational on the current count, asserted during the final cycle of a period.
// No backpressure; clear restarts the period, enable freezes nothing else.
module bit_period_counter
  import piso_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tc
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Terminal count only matters while the owner is actually shifting.
  assign tc = enable && (count == LAST);

  // Period counter: wraps to zero on its terminal count, so it can never overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tc ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: snapshots a word, shifts it out one bit per CLKS_PER_BIT clocks.
// Latency: first bit on ser_out the cycle after the accept edge; done pulses in the first IDLE cycle after the frame.
// Backpressure: load_ready is high only in IDLE (including the done cycle); loads are ignored while shifting.
// Optional macro PISO_PARITY_EN appends one even-parity bit period after the data bits.
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int MSB_FIRST    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int BW = cnt_width(NBITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [BW-1:0]    bit_cnt;
  logic             period_tc;
  logic             accept;
  logic             last_wrap;
  logic             first_bit;
  logic             nxt_bit;
`ifdef PISO_PARITY_EN
  logic             parity;
`endif

  assign load_ready = (state == ST_IDLE);
  assign busy       = (state == ST_SHIFT);
  assign accept     = load_valid && load_ready;
  assign last_wrap  = period_tc && (bit_cnt == LAST_BIT);
  assign first_bit  = (MSB_FIRST != 0) ? load_data[WIDTH-1] : load_data[0];

  bit_period_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_period (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (busy),
    .clear  (accept),
    .tc     (period_tc)
  );

  // Next-state logic: leave IDLE on an accepted load, return on the last cycle of the last bit.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)    state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_wrap) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Shift direction and the bit that follows the one currently on the line.
  always_comb begin
    shreg_nxt = shreg;
    nxt_bit   = IDLE_LEVEL;
    if (MSB_FIRST != 0) begin
      shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
      nxt_bit   = shreg[WIDTH-2];
    end else begin
      shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
      nxt_bit   = shreg[1];
    end
`ifdef PISO_PARITY_EN
    // After the last data bit the extra period carries the parity of the captured word.
    if (bit_cnt == BW'(WIDTH - 1)) begin
      nxt_bit = parity;
    end
`endif
  end

  // Datapath: capture on accept, advance one bit per period wrap, emit strobe/done pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      ser_out    <= IDLE_LEVEL;
      bit_strobe <= 1'b0;
      done       <= 1'b0;
`ifdef PISO_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      bit_strobe <= 1'b0;
      done       <= 1'b0;
      if (accept) begin
        shreg      <= load_data;
        bit_cnt    <= '0;
        ser_out    <= first_bit;
        bit_strobe <= 1'b1;
`ifdef PISO_PARITY_EN
        parity     <= ^load_data;
`endif
      end else if (period_tc) begin
        if (last_wrap) begin
          bit_cnt <= '0;
          ser_out <= IDLE_LEVEL;
          done    <= 1'b1;
        end else begin
          bit_cnt    <= bit_cnt + BW'(1);
          shreg      <= shreg_nxt;
          ser_out    <= nxt_bit;
          bit_strobe <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: two instances (MSB-first/2 clocks per bit and LSB-first/1 clock per bit).
// A frame-position model predicts every output each cycle; directed frames are also pinned to literals.
// Inputs are driven between edges, outputs sampled on the falling edge.
module tb_piso_shift_tx;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  localparam int CPB_A = 2;
  localparam int CPB_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         lv_a, lv_b;
  logic [W-1:0] ld_a, ld_b;
  logic         rdy_a, ser_a, stb_a, busy_a, done_a;
  logic         rdy_b, ser_b, stb_b, busy_b, done_b;

  piso_shift_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB_A), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .load_valid(lv_a), .load_ready(rdy_a), .load_data(ld_a),
    .ser_out(ser_a), .bit_strobe(stb_a), .busy(busy_a), .done(done_a));

  piso_shift_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB_B), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .load_valid(lv_b), .load_ready(rdy_b), .load_data(ld_b),
    .ser_out(ser_b), .bit_strobe(stb_b), .busy(busy_b), .done(done_b));

  int vec = 0;
  int err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: k = cycles since the accept edge (0 = idle, 1..F = frame, F+1 = done cycle).
  int           ka = 0, kb = 0;
  logic [W-1:0] wa = '0, wb = '0;
  bit           chk_en = 1'b0;

  // Expected {ser, strobe, busy, done, ready} for frame position k.
  function automatic logic [4:0] expect_out(input logic [W-1:0] w, input int k, input int cpb, input int msb);
    int   f;
    int   b;
    logic s;
    f = NB * cpb;
    if (k >= 1 && k <= f) begin
      b = (k - 1) / cpb;
      if (b == W) s = ^w;
      else        s = w[(msb != 0) ? (W - 1 - b) : b];
      return {s, ((k - 1) % cpb) == 0, 1'b1, 1'b0, 1'b0};
    end else if (k == f + 1) begin
      return 5'b1_0_0_1_1;
    end
    return 5'b1_0_0_0_1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      ka = 0;
      kb = 0;
    end else begin
      if ((ka == 0 || ka == NB * CPB_A + 1) && lv_a) begin wa = ld_a; ka = 1; end
      else if (ka != 0) ka = (ka == NB * CPB_A + 1) ? 0 : ka + 1;
      if ((kb == 0 || kb == NB * CPB_B + 1) && lv_b) begin wb = ld_b; kb = 1; end
      else if (kb != 0) kb = (kb == NB * CPB_B + 1) ? 0 : kb + 1;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [4:0] ea, eb;
    if (chk_en) begin
      ea = expect_out(wa, ka, CPB_A, 1);
      eb = expect_out(wb, kb, CPB_B, 0);
      chk("a_ser",   ser_a,  ea[4]); chk("a_strobe", stb_a, ea[3]);
      chk("a_busy",  busy_a, ea[2]); chk("a_done",   done_a, ea[1]);
      chk("a_ready", rdy_a,  ea[0]);
      chk("b_ser",   ser_b,  eb[4]); chk("b_strobe", stb_b, eb[3]);
      chk("b_busy",  busy_b, eb[2]); chk("b_done",   done_b, eb[1]);
      chk("b_ready", rdy_b,  eb[0]);
    end
  end

  // Sample capture for literal checks: index i = i-th cycle after a given edge.
  logic s_ser_a [1:128];
  logic s_ser_b [1:128];
  int   nstb_a, nstb_b, nbusy_a, ndone_a, ndone_b, done_at_a, done_at_b;

  task automatic record(input int n);
    nstb_a = 0; nstb_b = 0; nbusy_a = 0; ndone_a = 0; ndone_b = 0;
    done_at_a = 0; done_at_b = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      s_ser_a[i] = ser_a;
      s_ser_b[i] = ser_b;
      if (stb_a)  nstb_a++;
      if (stb_b)  nstb_b++;
      if (busy_a) nbusy_a++;
      if (done_a) begin ndone_a++; if (done_at_a == 0) done_at_a = i; end
      if (done_b) begin ndone_b++; if (done_at_b == 0) done_at_b = i; end
    end
  endtask

  function automatic logic [15:0] field16_a(input int start);
    logic [15:0] v = '0;
    for (int j = 0; j < 16; j++) v = {v[14:0], s_ser_a[start + j]};
    return v;
  endfunction

  initial begin
    int n;
    // Reset held 3 cycles with loads presented; they must be ignored.
    rst_n = 1'b0; lv_a = 1'b1; ld_a = 8'hFF; lv_b = 1'b1; ld_b = 8'hFF;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; lv_a = 1'b0; lv_b = 1'b0;
    @(negedge clk);
    chk("rst_ser",   ser_a,  1'b1);
    chk("rst_busy",  busy_a, 1'b0);
    chk("rst_done",  done_a, 1'b0);
    chk("rst_ready", rdy_a,  1'b1);
    chk("rst_busy_b", busy_b, 1'b0);

    // MSB-first 0xA5 on A, LSB-first 0x01 on B; data changed right after accept.
    @(negedge clk);
    lv_a = 1'b1; ld_a = 8'hA5; lv_b = 1'b1; ld_b = 8'h01;
    @(posedge clk); #1;
    lv_a = 1'b0; ld_a = 8'h5A; lv_b = 1'b0; ld_b = 8'hFE;
    n = NB * CPB_A + 1;
    record(n);
    chk("a5_bits",    field16_a(1), 16'hCC33);
    chk("a5_strobes", nstb_a,  NB);
    chk("a5_busy",    nbusy_a, NB * CPB_A);
    chk("a5_done_at", done_at_a, NB * CPB_A + 1);
    chk("a5_ndone",   ndone_a, 1);
    begin
      logic [7:0] v = '0;
      for (int j = 1; j <= 8; j++) v = {v[6:0], s_ser_b[j]};
      chk("lsb01_bits", v, 8'b1000_0000);
    end
    chk("lsb01_strobes", nstb_b, NB);
    chk("lsb01_done_at", done_at_b, NB + 1);

    // Back-to-back on A: 0x3C then 0xC3 with load_valid held, data churned mid-frame.
    @(negedge clk);
    lv_a = 1'b1; ld_a = 8'h3C;
    @(posedge clk); #1;
    ld_a = 8'h55;
    nstb_a = 0; ndone_a = 0; done_at_a = 0;
    for (int i = 1; i <= 4 * NB + 2; i++) begin
      @(negedge clk);
      s_ser_a[i] = ser_a;
      if (done_a) begin
        ndone_a++;
        if (done_at_a == 0) done_at_a = i;
        else chk("b2b_done2_at", i, 4 * NB + 2);
      end
      if (i == 2 * NB + 1) chk("b2b_ready_in_done", rdy_a, 1'b1);
      if (i == 5) ld_a = 8'hC3;
      if (i == 2 * NB + 2) lv_a = 1'b0;
    end
    chk("b2b_first_bits",  field16_a(1), 16'h0FF0);
    chk("b2b_done1_at",    done_at_a, 2 * NB + 1);
    chk("b2b_second_bits", field16_a(2 * NB + 2), 16'hF00F);
    chk("b2b_ndone",       ndone_a, 2);

    // Reset at the start of bit 4 of 0xFF aborts the frame without a done pulse.
    @(negedge clk);
    lv_a = 1'b1; ld_a = 8'hFF;
    @(posedge clk); #1;
    lv_a = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_strobe_bit4", stb_a, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ser",   ser_a,  1'b1);
    chk("abort_busy",  busy_a, 1'b0);
    chk("abort_done",  done_a, 1'b0);
    chk("abort_ready", rdy_a,  1'b1);
    rst_n = 1'b1;
    record(2 * NB + 1);
    chk("abort_no_done", ndone_a, 0);
    chk("abort_no_busy", nbusy_a, 0);
    @(negedge clk);
    lv_a = 1'b1; ld_a = 8'h0F;
    @(posedge clk); #1;
    lv_a = 1'b0;
    record(NB * CPB_A + 1);
    chk("post_abort_bits",    field16_a(1), 16'h00FF);
    chk("post_abort_done_at", done_at_a, NB * CPB_A + 1);

`ifdef PISO_PARITY_EN
    // Parity: 0x07 has odd weight (parity 1), 0x03 even weight (parity 0).
    @(negedge clk);
    lv_a = 1'b1; ld_a = 8'h07;
    @(posedge clk); #1;
    lv_a = 1'b0;
    record(NB * CPB_A + 1);
    chk("par07_bits",    field16_a(1), 16'h003F);
    chk("par07_parity",  {s_ser_a[17], s_ser_a[18]}, 2'b11);
    chk("par07_strobes", nstb_a, 9);
    chk("par07_done_at", done_at_a, 9 * CPB_A + 1);
    @(negedge clk);
    lv_a = 1'b1; ld_a = 8'h03;
    @(posedge clk); #1;
    lv_a = 1'b0;
    record(NB * CPB_A + 1);
    chk("par03_bits",   field16_a(1), 16'h000F);
    chk("par03_parity", {s_ser_a[17], s_ser_a[18]}, 2'b00);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
